// File: rtl/latency_sched_pkg.sv
// Shared types for the latency chain scheduler: FSM states, chain stage record
// and the depth clamp used when a new chain depth is accepted.
package latency_sched_pkg;

    // Stage record widths match the scheduler's default payload and id widths.
    localparam int STAGE_WIDTH = 32;
    localparam int STAGE_ID_W  = 2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        SWITCH
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [STAGE_ID_W-1:0] id;
        logic [STAGE_WIDTH-1:0] data;
    } stage_t;

    function automatic int clamp_depth(input int req, input int lo, input int hi);
        if (req < lo) return lo;
        if (req > hi) return hi;
        return req;
    endfunction

endpackage

// File: rtl/latency_select_chain.sv
// Fixed-length shift chain of stage records with an output tap chosen by depth;
// depth 0 routes the input straight to the output in the same cycle.
module latency_select_chain
    import latency_sched_pkg::*;
#(
    parameter int MAX_DEPTH = 8,
    parameter int DEPTH_W   = $clog2(MAX_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DEPTH_W-1:0] depth,
    input  stage_t             in_stage,
    output stage_t             out_stage
);

    if (MAX_DEPTH > 0) begin : g_chain
        stage_t stage_reg [1:MAX_DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 1; k <= MAX_DEPTH; k++) begin
                    stage_reg[k] <= '0;
                end
            end else begin
                stage_reg[1] <= in_stage;
                for (int k = 2; k <= MAX_DEPTH; k++) begin
                    stage_reg[k] <= stage_reg[k-1];
                end
            end
        end

        always_comb begin
            out_stage = in_stage;
            for (int k = 1; k <= MAX_DEPTH; k++) begin
                if (int'(depth) == k) out_stage = stage_reg[k];
            end
        end
    end else begin : g_bypass
        assign out_stage = in_stage;
    end

endmodule

// File: rtl/kanagawa_latency_chain_scheduler.sv
// Round-robin issue of NUM_REQ requesters into one shared variable-depth chain;
// depth changes wait until every in-flight beat has left the chain.
module kanagawa_latency_chain_scheduler
    import latency_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = STAGE_WIDTH,
    parameter int MIN_DEPTH = 0,
    parameter int MAX_DEPTH = 8,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DEPTH_W  = $clog2(MAX_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     cfg_valid,
    input  logic [DEPTH_W-1:0]       cfg_depth,
    output logic                     cfg_ready,
    output logic [DEPTH_W-1:0]       depth_current,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic [DEPTH_W-1:0]       inflight,
    output logic                     busy
);

    state_t             state_reg;
    logic [ID_W-1:0]    rr_ptr_reg;
    logic [DEPTH_W-1:0] depth_reg;
    logic [DEPTH_W-1:0] pending_depth_reg;
    logic [DEPTH_W-1:0] inflight_reg;

    logic [WIDTH-1:0]   lane_data [NUM_REQ];
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               issue;
    logic               emit;
    stage_t             in_stage;
    stage_t             out_stage;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_data[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    // Scan offsets from the far end so the closest valid requester to rr_ptr wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr_reg) + off) % NUM_REQ;
            if (req_valid[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

    assign req_ready = (state_reg == RUN) ? grant : '0;
    assign issue     = |(req_valid & req_ready);

    always_comb begin
        in_stage.valid = issue;
        in_stage.id    = grant_idx;
        in_stage.data  = lane_data[grant_idx];
    end

    latency_select_chain #(
        .MAX_DEPTH (MAX_DEPTH),
        .DEPTH_W   (DEPTH_W)
    ) u_chain (
        .clk       (clk),
        .rst       (rst),
        .depth     (depth_reg),
        .in_stage  (in_stage),
        .out_stage (out_stage)
    );

    assign emit = out_stage.valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= RUN;
            rr_ptr_reg        <= '0;
            depth_reg         <= DEPTH_W'(MAX_DEPTH);
            pending_depth_reg <= DEPTH_W'(MAX_DEPTH);
            inflight_reg      <= '0;
        end else begin
            inflight_reg <= inflight_reg + DEPTH_W'(issue) - DEPTH_W'(emit);
            if (issue) begin
                rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            case (state_reg)
                RUN: begin
                    if (cfg_valid) begin
                        pending_depth_reg <= DEPTH_W'(clamp_depth(int'(cfg_depth), MIN_DEPTH, MAX_DEPTH));
                        state_reg         <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight_reg == '0) state_reg <= SWITCH;
                end
                SWITCH: begin
                    depth_reg <= pending_depth_reg;
                    state_reg <= RUN;
                end
                default: state_reg <= RUN;
            endcase
        end
    end

    assign cfg_ready     = (state_reg == RUN);
    assign depth_current = depth_reg;
    assign inflight      = inflight_reg;
    assign busy          = (state_reg != RUN) || (inflight_reg != '0);
    assign resp_valid    = out_stage.valid;
    assign resp_data     = out_stage.data;
    assign resp_id       = out_stage.id;

endmodule

// File: tb/tb_kanagawa_latency_chain_scheduler.sv
// Scoreboard bench: every observed issue queues its expected response, which
// is checked when resp_valid fires; scenario steps check arbitration and FSM timing.
module tb_kanagawa_latency_chain_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 32;
    localparam int MAX_DEPTH = 8;
    localparam int ID_W      = 2;
    localparam int DEPTH_W   = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_valid = '0;
    logic [NUM_REQ*WIDTH-1:0] req_data = '0;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     cfg_valid = 1'b0;
    logic [DEPTH_W-1:0]       cfg_depth = '0;
    logic                     cfg_ready;
    logic [DEPTH_W-1:0]       depth_current;
    logic                     resp_valid;
    logic [WIDTH-1:0]         resp_data;
    logic [ID_W-1:0]          resp_id;
    logic [DEPTH_W-1:0]       inflight;
    logic                     busy;

    kanagawa_latency_chain_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .MIN_DEPTH (0),
        .MAX_DEPTH (MAX_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .cfg_valid     (cfg_valid),
        .cfg_depth     (cfg_depth),
        .cfg_ready     (cfg_ready),
        .depth_current (depth_current),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_id       (resp_id),
        .inflight      (inflight),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   model_depth = MAX_DEPTH;

    // Monitor: samples on the falling edge, pushes on issue, pops on response.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            check("inflight_model", 64'(inflight), 64'(sb.size()));
            check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    e.id   = ID_W'(i);
                    e.data = req_data[i*WIDTH +: WIDTH];
                    e.due  = cyc + model_depth;
                    sb.push_back(e);
                end
            end
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    $display("resp cycle=%0d id=%0d data=%08h due=%0d", cyc, resp_id, resp_data, e.due);
                    check("resp_id", 64'(resp_id), 64'(e.id));
                    check("resp_data", 64'(resp_data), 64'(e.data));
                    check("resp_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NUM_REQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i*WIDTH +: WIDTH] = $urandom;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive('0);
            tick();
        end
    endtask

    // Depth change on an empty chain; returns at the falling edge of the first RUN cycle.
    task automatic cfg_empty(input int d, input int exp_d, input logic [NUM_REQ-1:0] v);
        drive('0);
        cfg_valid = 1'b1;
        cfg_depth = DEPTH_W'(d);
        @(negedge clk);
        check("cfg_ready_accept", 64'(cfg_ready), 64'd1);
        tick();
        cfg_valid = 1'b0;
        drive(v);
        @(negedge clk);
        check("drain_state", 64'({cfg_ready, busy, req_ready == '0}), 64'b011);
        tick();
        drive(v);
        @(negedge clk);
        check("switch_state", 64'({cfg_ready, busy, req_ready == '0}), 64'b011);
        tick();
        model_depth = exp_d;
        drive(v);
        @(negedge clk);
        check("run_again", 64'(cfg_ready), 64'd1);
        check("depth_after_cfg", 64'(depth_current), 64'(exp_d));
    endtask

    initial begin
        int first_zero;
        int n;
        bit done;

        tick();
        tick();
        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_depth", 64'(depth_current), 64'(MAX_DEPTH));
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        tick();
        rst = 1'b0;

        // All four requesters: strict rotation, chain fills to MAX_DEPTH and holds.
        for (int k = 0; k < 8; k++) begin
            drive(4'hF);
            @(negedge clk);
            check("rr_all", 64'(req_ready), 64'(1 << (k % 4)));
            check("inflight_fill", 64'(inflight), 64'(k));
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            drive(4'hF);
            @(negedge clk);
            check("inflight_hold", 64'(inflight), 64'd8);
            tick();
        end
        idle(3);

        // Depth 2 accepted with 5 beats in flight; the accept-cycle grant still issues.
        drive(4'b1000);
        cfg_valid = 1'b1;
        cfg_depth = 4'd2;
        @(negedge clk);
        check("inflight_at_cfg", 64'(inflight), 64'd5);
        check("cfg_accept_grant", 64'(req_ready), 64'b1000);
        tick();
        cfg_valid   = 1'b0;
        model_depth = 2;
        first_zero  = -1;
        n           = 0;
        done        = 1'b0;
        while (!done && n < 40) begin
            drive(4'b1000);
            @(negedge clk);
            if (req_ready != '0) begin
                done = 1'b1;
            end else begin
                if (inflight == '0 && first_zero < 0) first_zero = n;
                n++;
                tick();
            end
        end
        check("drain_timeout", 64'(done), 64'd1);
        check("drain_exit_gap", 64'(n - first_zero), 64'd2);
        check("depth2", 64'(depth_current), 64'd2);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(4'b1000);
            tick();
        end
        idle(10);

        // Depth 3 with requesters 0 and 2: grants alternate 0, 2, ...
        cfg_empty(3, 3, 4'b0101);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                drive(4'b0101);
                @(negedge clk);
            end
            check("rr_0_2", 64'(req_ready), (k % 2 == 0) ? 64'b0001 : 64'b0100);
            tick();
        end
        idle(6);

        // Out-of-range request clamps to MAX_DEPTH.
        cfg_empty(15, 8, 4'b0000);
        tick();

        // Depth 0: response is the issuing beat in the same cycle.
        cfg_empty(0, 0, 4'b0110);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                drive(4'b0110);
                @(negedge clk);
            end
            check("d0_resp_eq_issue", 64'(resp_valid), 64'(|(req_valid & req_ready)));
            check("d0_inflight", 64'(inflight), 64'd0);
            tick();
        end
        idle(2);

        // Reset with four beats in flight at depth 5.
        cfg_empty(5, 5, 4'b0110);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                drive(4'b0110);
                @(negedge clk);
            end
            tick();
        end
        drive('0);
        @(negedge clk);
        check("inflight_pre_rst", 64'(inflight), 64'd4);
        tick();
        rst         = 1'b1;
        model_depth = MAX_DEPTH;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_inflight", 64'(inflight), 64'd0);
        check("post_rst_depth", 64'(depth_current), 64'(MAX_DEPTH));
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            check("post_rst_no_resp", 64'(resp_valid), 64'd0);
        end
        tick();
        drive(4'hF);
        @(negedge clk);
        check("post_rst_grant", 64'(req_ready), 64'b0001);
        tick();
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/kanagawa_latency_chain_scheduler.md
# kanagawa_latency_chain_scheduler

Controller that shares one variable-depth register chain between NUM_REQ requesters. It arbitrates issue into the chain round-robin and tags each beat with its requester id. It tracks beats in flight and reconfigures the chain depth only after the chain has fully drained. It sits in front of shared fixed-function datapaths whose latency is set at run time, and in simulation it is the harness that exercises latency changes deterministically.

## Interface
- NUM_REQ, 4: number of requesters, >= 1
- WIDTH, 32: payload width
- MIN_DEPTH, 0: smallest legal chain depth
- MAX_DEPTH, 8: largest legal chain depth, >= MIN_DEPTH
- ID_W (derived), max(1, $clog2(NUM_REQ)); DEPTH_W (derived), $clog2(MAX_DEPTH)+1
---
- clk  in  1  clock; the block uses one clock; all logic is on its rising edge
- rst  in  1  reset, synchronous and active-high
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ x WIDTH  per-requester payload
- req_ready  out  NUM_REQ  one-hot grant; a beat issues when req_valid[i] & req_ready[i]
- cfg_valid  in  1  depth change request
- cfg_depth  in  DEPTH_W  requested depth
- cfg_ready  out  1  high only in RUN
- depth_current  out  DEPTH_W  active depth; reset value MAX_DEPTH
- resp_valid  out  1  beat leaving the chain; reset value 0
- resp_data  out  WIDTH  payload of that beat; reset value 0
- resp_id  out  ID_W  requester that issued the beat; reset value 0
- inflight  out  DEPTH_W  number of issued beats not yet emitted; reset value 0
- busy  out  1  state != RUN or inflight != 0; reset value 0

## Operation
- FSM states: RUN, DRAIN, SWITCH. Reset state is RUN.
- RUN:
  - Grants go to the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - After an issue, rr_ptr moves to granted+1, mod NUM_REQ.
  - With no valid request, req_ready is all zero and rr_ptr holds.
- cfg handshake is cfg_valid & cfg_ready.
  - On accept, the requested depth is latched, clamped into [MIN_DEPTH, MAX_DEPTH], and the FSM moves to DRAIN.
  - A grant in the accept cycle still issues.
- DRAIN:
  - req_ready is all zero.
  - When inflight == 0, the FSM moves to SWITCH.
- SWITCH: lasts one cycle. req_ready is all zero. depth_current takes the latched depth. The FSM then returns to RUN.
- Chain behaviour:
  - A beat that issues with depth D is emitted exactly D cycles later.
  - With D == 0, the beat is emitted combinationally in the same cycle.
  - Each chain stage carries {valid, id, data}. Stage valids clear on reset.
- inflight arithmetic:
  - inflight_next = inflight + issue - emit.
  - With D == 0, issue and emit in the same cycle leave inflight unchanged.
  - The maximum value is MAX_DEPTH, so the counter cannot overflow.
- Reset mid-operation:
  - All in-flight beats are discarded and no resp_valid follows reset.
  - depth_current returns to MAX_DEPTH and rr_ptr returns to 0.
- If cfg_depth equals depth_current, the block still runs the full DRAIN and SWITCH sequence. No shortcut.

## Timing
- Issue to resp_valid latency is depth_current cycles.
- cfg accept at cycle t:
  - With the chain empty after cycle t, DRAIN is at t+1, SWITCH at t+2, and the first grant at the new depth is at t+3.
  - Otherwise DRAIN lasts until the last beat emits, plus one cycle.
- Throughput in RUN is one beat per cycle. With all requesters valid, each requester gets one grant every NUM_REQ cycles.
- req_ready depends combinationally on req_valid, rr_ptr and state. It has no dependence on resp.
- During DRAIN, resp_valid may assert. Responses always use the depth that was active when the beat issued.

## Structure
- Shared package latency_sched_pkg holds:
  - the state enum {RUN, DRAIN, SWITCH}
  - the stage struct {valid, id, data}
  - a clamp_depth function
- Sub-module latency_select_chain:
  - MAX_DEPTH stages of the stage struct
  - output mux selected by depth_current; depth 0 bypasses the stages
- The top level holds the round-robin arbiter, the FSM, and the inflight counter.

## Test plan
- Depth 3, requesters 0 and 2 valid continuously:
  - grants alternate 0, 2, 0, 2
  - each resp arrives exactly 3 cycles after its issue, with the matching resp_id and resp_data
- All 4 requesters valid for 8 cycles from reset:
  - grant order is 0, 1, 2, 3, 0, 1, 2, 3
  - inflight reaches 8 at MAX_DEPTH = 8, then holds at 8
- cfg_depth = 2 accepted while inflight = 5:
  - req_ready stays 0 until inflight == 0, then for one more SWITCH cycle
  - depth_current becomes 2
  - the next beat emits 2 cycles after issue
- cfg_depth = 0 on an empty chain:
  - RUN, DRAIN, SWITCH, RUN
  - afterwards resp_valid equals issue in the same cycle and inflight stays 0
- cfg_depth = 15 with MAX_DEPTH = 8: clamped, depth_current becomes 8.
- rst asserted for 1 cycle with 4 beats in flight:
  - no resp_valid after reset
  - inflight = 0, depth_current = 8, and the next grant goes to requester 0
